// File: rtl/peridot_scif_pkg.sv
// Shared types and frame constants for the PERIDOT SCIF host.
package peridot_scif_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic {
    RX_HUNT = 1'b0,
    RX_DATA = 1'b1
  } rx_state_t;

  localparam logic       SCIF_START_BIT = 1'b0;
  localparam logic       SCIF_IDLE_BIT  = 1'b1;
  localparam int         SCIF_DATA_BITS = 8;
  localparam logic [2:0] SCIF_LAST_BIT  = 3'(SCIF_DATA_BITS - 1);

endpackage

// File: rtl/peridot_scif_host_rxfifo.sv
// Two-entry receive FIFO; the second slot absorbs the frame the target may
// already have launched before it observes scif_rxr_n rising.
module peridot_scif_host_rxfifo (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic [1:0] count
);

  logic [7:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       do_pop;
  logic       do_push;

  assign do_pop  = pop & (count != 2'd0);
  // A push into a full FIFO is dropped unless a pop frees the slot this cycle.
  assign do_push = push & ((count != 2'd2) | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= 8'h00;
      mem[1] <= 8'h00;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/peridot_scif_host.sv
// SCIF initiator: sclk divider, TX/RX framers and the receive FIFO.
//   state    | meaning
//   TX_IDLE  | txd=1, wait for a held byte and target ready
//   TX_START | start bit on txd, holding register moved to shifter
//   TX_DATA  | data bits 0..7, LSB first
//   TX_STOP  | one stop bit, then back to idle
//   RX_HUNT  | waiting for a sampled start bit
//   RX_DATA  | shifting in 8 data bits
module peridot_scif_host
  import peridot_scif_pkg::*;
#(
  parameter int CLKDIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       in_ready,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       scif_sclk,
  output logic       scif_txd,
  input  logic       scif_txr_n,
  input  logic       scif_rxd,
  output logic       scif_rxr_n
);

  localparam int               DIV_W    = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);

  logic [DIV_W-1:0] div;
  logic             wrap;
  logic             rise;
  logic             fall;

  logic txr_q;
  logic rxd_q;
  logic txr_s;

  tx_state_t  tx_state;
  tx_state_t  tx_next;
  logic       tx_full;
  logic [7:0] tx_hold;
  logic [7:0] tx_sr;
  logic [2:0] tx_bit;
  logic       tx_load;
  logic       tx_shift;
  logic       txd_d;

  rx_state_t  rx_state;
  rx_state_t  rx_next;
  logic [7:0] rx_sr;
  logic [2:0] rx_bit;
  logic       rx_shift;
  logic       rx_push;
  logic [7:0] rx_byte;
  logic [1:0] fifo_count;

  // rise/fall mark the clk cycle whose closing edge moves scif_sclk, so
  // sampling and txd updates land exactly on the sclk transitions.
  assign wrap = (div == DIV_LAST);
  assign rise = wrap & ~scif_sclk;
  assign fall = wrap & scif_sclk;

  always_ff @(posedge clk) begin
    if (reset) begin
      div       <= '0;
      scif_sclk <= 1'b0;
    end else if (wrap) begin
      div       <= '0;
      scif_sclk <= ~scif_sclk;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      txr_q <= 1'b1;
      rxd_q <= 1'b1;
      txr_s <= 1'b1;
    end else begin
      txr_q <= scif_txr_n;
      rxd_q <= scif_rxd;
      if (rise) begin
        txr_s <= txr_q;
      end
    end
  end

  assign in_ready = ~tx_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
    end else begin
      tx_state <= tx_next;
    end
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (fall && tx_full && !txr_s)           tx_next = TX_START;
      TX_START: if (fall)                                tx_next = TX_DATA;
      TX_DATA:  if (fall && (tx_bit == SCIF_LAST_BIT))   tx_next = TX_STOP;
      TX_STOP:  if (fall)                                tx_next = TX_IDLE;
      default:                                           tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    txd_d    = scif_txd;
    if (fall) begin
      case (tx_next)
        TX_START: begin
          txd_d   = SCIF_START_BIT;
          tx_load = 1'b1;
        end
        TX_DATA: begin
          txd_d    = tx_sr[0];
          tx_shift = 1'b1;
        end
        default: txd_d = SCIF_IDLE_BIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scif_txd <= SCIF_IDLE_BIT;
      tx_full  <= 1'b0;
      tx_hold  <= 8'h00;
      tx_sr    <= 8'h00;
      tx_bit   <= 3'd0;
    end else begin
      scif_txd <= txd_d;
      if (tx_load) begin
        tx_sr   <= tx_hold;
        tx_full <= 1'b0;
        tx_bit  <= 3'd0;
      end else if (in_valid && in_ready) begin
        tx_hold <= in_data;
        tx_full <= 1'b1;
      end
      if (tx_shift) begin
        tx_sr <= {1'b0, tx_sr[7:1]};
        // The START->DATA shift puts bit 0 on the line, so the count stays 0.
        if (tx_state == TX_DATA) begin
          tx_bit <= tx_bit + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_HUNT;
    end else begin
      rx_state <= rx_next;
    end
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_HUNT: if (rise && (rxd_q == SCIF_START_BIT))   rx_next = RX_DATA;
      RX_DATA: if (rise && (rx_bit == SCIF_LAST_BIT))   rx_next = RX_HUNT;
      default:                                          rx_next = RX_HUNT;
    endcase
  end

  always_comb begin
    rx_shift = rise & (rx_state == RX_DATA);
    rx_push  = rx_shift & (rx_bit == SCIF_LAST_BIT);
    rx_byte  = {rxd_q, rx_sr[7:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sr  <= 8'h00;
      rx_bit <= 3'd0;
    end else if (rx_shift) begin
      rx_sr  <= rx_byte;
      rx_bit <= rx_bit + 3'd1;
    end else if (rx_state == RX_HUNT) begin
      rx_bit <= 3'd0;
    end
  end

  peridot_scif_host_rxfifo u_rxfifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_byte),
    .pop       (out_ready),
    .head      (out_data),
    .count     (fifo_count)
  );

  assign out_valid = (fifo_count != 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      scif_rxr_n <= 1'b1;
    end else begin
      scif_rxr_n <= (fifo_count != 2'd0);
    end
  end

endmodule
